// File: rtl/issue_queue_multiport_if.sv
// ---------------------------------------------------------------------------
// issue_queue_multiport_if
//
// Bundles the decode-side push bus, the issue-side pop bus and the status
// flags of the multi-issue instruction queue.
//
//   flash            : synchronous flush request (clears the queue)
//   stall            : blocks pop for this cycle; push is unaffected
//   in_data          : PUSH_W packed elements, slot 0 = oldest
//   in_data_number   : number of valid push slots (low slots)
//   out_data_number  : number of elements issue consumes this cycle
//   out_data         : POP_W oldest entries, slot 0 = head
//   out_valid        : bit i set when out_data slot i holds a live entry
//   iq_size          : occupied entries
//   iq_size_left     : free entries
//   almost_full      : free entries below the almost-full threshold
//   overflow_err     : one-cycle pulse, a push was rejected
//   underflow_err    : one-cycle pulse, a pop request was clamped
//
// Modports: master = decode/issue side, slave = the queue itself.
// ---------------------------------------------------------------------------
interface issue_queue_multiport_if #(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2,
    parameter int ELEM_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IN_W  = $clog2(PUSH_W + 1);
    localparam int OUT_W = $clog2(POP_W + 1);

    logic                     flash;
    logic                     stall;
    logic [PUSH_W*ELEM_W-1:0] in_data;
    logic [IN_W-1:0]          in_data_number;
    logic [OUT_W-1:0]         out_data_number;
    logic [POP_W*ELEM_W-1:0]  out_data;
    logic [POP_W-1:0]         out_valid;
    logic [CNT_W-1:0]         iq_size;
    logic [CNT_W-1:0]         iq_size_left;
    logic                     almost_full;
    logic                     overflow_err;
    logic                     underflow_err;

    modport master (
        output flash, stall, in_data, in_data_number, out_data_number,
        input  out_data, out_valid, iq_size, iq_size_left, almost_full,
               overflow_err, underflow_err
    );

    modport slave (
        input  flash, stall, in_data, in_data_number, out_data_number,
        output out_data, out_valid, iq_size, iq_size_left, almost_full,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/issue_queue_multiport.sv
// ---------------------------------------------------------------------------
// issue_queue_multiport
//
// Parametrised multi-issue instruction queue sitting between decode and
// issue. Up to PUSH_W elements are accepted per cycle (all-or-nothing against
// the free space at cycle start) and the POP_W oldest entries are always
// presented to issue, which consumes out_data_number of them per cycle.
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   iq    : issue_queue_multiport_if.slave (push/pop buses and status)
//
// All status and output data are combinational from registered state only,
// so a pushed element becomes visible one cycle after its push.
// Full and empty are told apart by the occupancy counter, never by pointer
// equality. POP_W is expected not to exceed DEPTH.
// ---------------------------------------------------------------------------
module issue_queue_multiport #(
    parameter int DEPTH     = 8,
    parameter int PUSH_W    = 4,
    parameter int POP_W     = 2,
    parameter int ELEM_W    = 64,
    parameter int AF_THRESH = 4
) (
    input  logic clk,
    input  logic rst_n,
    issue_queue_multiport_if.slave iq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] head_reg,  head_next;
    logic [PTR_W-1:0] tail_reg,  tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_err_reg,  overflow_err_next;
    logic             underflow_err_reg, underflow_err_next;

    // Element storage, one register per entry (no reset on the payload)
    logic [ELEM_W-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_req;
    logic [CNT_W-1:0] free_entries;
    logic             push_illegal;
    logic             push_accept;
    logic [CNT_W-1:0] push_acc_n;
    logic [CNT_W-1:0] pop_n;

    assign push_n       = CNT_W'(iq.in_data_number);
    assign pop_req      = CNT_W'(iq.out_data_number);
    assign free_entries = CNT_W'(DEPTH) - count_reg;
    // A slot count above PUSH_W cannot be honoured and is rejected outright.
    assign push_illegal = (push_n > CNT_W'(PUSH_W));

    always_comb begin
        push_accept        = 1'b0;
        push_acc_n         = '0;
        pop_n              = '0;
        overflow_err_next  = 1'b0;
        underflow_err_next = 1'b0;

        if (!iq.flash) begin
            // Space is judged before this cycle's pops: a same-cycle pop
            // never makes room for a same-cycle push.
            if (!push_illegal && (push_n <= free_entries)) begin
                push_accept = 1'b1;
                push_acc_n  = push_n;
            end else begin
                overflow_err_next = (push_n != '0);
            end

            if (!iq.stall) begin
                if (pop_req > count_reg) begin
                    pop_n              = count_reg;
                    underflow_err_next = 1'b1;
                end else begin
                    pop_n = pop_req;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pointer and occupancy update; flash wins over everything else
    // -----------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg + PTR_W'(pop_n);
        tail_next  = tail_reg + PTR_W'(push_acc_n);
        count_next = count_reg + push_acc_n - pop_n;
        if (iq.flash) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            overflow_err_reg  <= 1'b0;
            underflow_err_reg <= 1'b0;
        end else begin
            head_reg          <= head_next;
            tail_reg          <= tail_next;
            count_reg         <= count_next;
            overflow_err_reg  <= overflow_err_next;
            underflow_err_reg <= underflow_err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Push write path: each push slot targets tail + slot (wrapping modulo
    // DEPTH), so a burst crossing entry DEPTH-1 splits naturally. Slot
    // addresses within one burst are distinct because PUSH_W <= DEPTH.
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] slot_addr [PUSH_W];
    logic             slot_live [PUSH_W];

    for (genvar gi = 0; gi < PUSH_W; gi++) begin : g_slot
        assign slot_addr[gi] = tail_reg + PTR_W'(gi);
        assign slot_live[gi] = push_accept && (CNT_W'(gi) < push_acc_n);
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic              entry_we;
        logic [ELEM_W-1:0] entry_wd;
        logic [ELEM_W-1:0] entry_reg;

        always_comb begin
            entry_we = 1'b0;
            entry_wd = '0;
            for (int s = 0; s < PUSH_W; s++) begin
                if (slot_live[s] && (slot_addr[s] == PTR_W'(gi))) begin
                    entry_we = 1'b1;
                    entry_wd = iq.in_data[s*ELEM_W +: ELEM_W];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (entry_we) begin
                entry_reg <= entry_wd;
            end
        end

        assign mem[gi] = entry_reg;
    end

    // -----------------------------------------------------------------------
    // Issue-side read: slot i shows entry head + i
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < POP_W; gi++) begin : g_read
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx = head_reg + PTR_W'(gi);
        assign iq.out_data[gi*ELEM_W +: ELEM_W] = mem[rd_idx];
        assign iq.out_valid[gi] = (32'(count_reg) > gi);
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    assign iq.iq_size       = count_reg;
    assign iq.iq_size_left  = free_entries;
    assign iq.almost_full   = (32'(free_entries) < AF_THRESH);
    assign iq.overflow_err  = overflow_err_reg;
    assign iq.underflow_err = underflow_err_reg;

endmodule

// File: tb/tb_issue_queue_multiport.sv
module tb_issue_queue_multiport;
    localparam int DEPTH  = 8;
    localparam int PUSH_W = 4;
    localparam int POP_W  = 2;
    localparam int ELEM_W = 64;

    logic clk;
    logic rst_n;
    int   asserts;
    int   errors;

    issue_queue_multiport_if #(
        .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .ELEM_W(ELEM_W)
    ) iq_if ();

    issue_queue_multiport #(
        .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .ELEM_W(ELEM_W),
        .AF_THRESH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ELEM_W-1:0] slot0;
    logic [ELEM_W-1:0] slot1;
    assign slot0 = iq_if.out_data[0*ELEM_W +: ELEM_W];
    assign slot1 = iq_if.out_data[1*ELEM_W +: ELEM_W];

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic drive(input int n_push, input int first_tag, input int n_pop,
                         input logic st, input logic fl);
        logic [PUSH_W*ELEM_W-1:0] d;
        d = '0;
        for (int s = 0; s < PUSH_W; s++) d[s*ELEM_W +: ELEM_W] = 64'(first_tag + s);
        iq_if.in_data         = d;
        iq_if.in_data_number  = 3'(n_push);
        iq_if.out_data_number = 2'(n_pop);
        iq_if.stall           = st;
        iq_if.flash           = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t size=%0d left=%0d valid=%b af=%b ovf=%b udf=%b s0=%h s1=%h",
                 $time, iq_if.iq_size, iq_if.iq_size_left, iq_if.out_valid,
                 iq_if.almost_full, iq_if.overflow_err, iq_if.underflow_err, slot0, slot1);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
        #12;
        asserts++; if (iq_if.iq_size !== 4'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", iq_if.iq_size); end
        asserts++; if (iq_if.iq_size_left !== 4'd8) begin errors++; $display("FAIL reset_left: got %0d expected 8", iq_if.iq_size_left); end
        asserts++; if (iq_if.out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", iq_if.out_valid); end
        asserts++; if (iq_if.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", iq_if.almost_full); end
        asserts++; if (iq_if.overflow_err !== 1'b0 || iq_if.underflow_err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0", iq_if.overflow_err, iq_if.underflow_err); end
        rst_n = 1'b1;
        step();
        asserts++; if (iq_if.iq_size !== 4'd0) begin errors++; $display("FAIL idle_size: got %0d expected 0", iq_if.iq_size); end
    endtask

    task automatic test_push_pop();
        drive(4, 'h11, 0, 1'b0, 1'b0);
        step();
        asserts++; if (slot0 !== 64'h11 || slot1 !== 64'h12) begin errors++;
            $display("FAIL first_push_data: got %h %h expected 11 12", slot0, slot1); end
        asserts++; if (iq_if.out_valid !== 2'b11) begin errors++; $display("FAIL first_push_valid: got %b expected 11", iq_if.out_valid); end
        asserts++; if (iq_if.iq_size !== 4'd4) begin errors++; $display("FAIL first_push_size: got %0d expected 4", iq_if.iq_size); end
        drive(3, 'h15, 1, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.iq_size !== 4'd6) begin errors++; $display("FAIL mixed_size: got %0d expected 6", iq_if.iq_size); end
        asserts++; if (slot0 !== 64'h12) begin errors++; $display("FAIL mixed_head: got %h expected 12", slot0); end
        asserts++; if (iq_if.almost_full !== 1'b1 || iq_if.iq_size_left !== 4'd2) begin errors++;
            $display("FAIL mixed_af: got af=%b left=%0d expected 1 2", iq_if.almost_full, iq_if.iq_size_left); end
    endtask

    task automatic test_overflow();
        // Queue holds 0x12..0x17; top up to full
        drive(2, 'h18, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.iq_size !== 4'd8 || iq_if.iq_size_left !== 4'd0) begin errors++;
            $display("FAIL full_size: got %0d/%0d expected 8/0", iq_if.iq_size, iq_if.iq_size_left); end
        drive(1, 'hAA, 2, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", iq_if.overflow_err); end
        asserts++; if (iq_if.iq_size !== 4'd6) begin errors++; $display("FAIL ovf_size: got %0d expected 6", iq_if.iq_size); end
        asserts++; if (slot0 !== 64'h14) begin errors++; $display("FAIL ovf_head: got %h expected 14", slot0); end
        drive(0, 0, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", iq_if.overflow_err); end
        // Drain 0x14..0x19 in pairs; the rejected 0xAA must not appear
        for (int k = 0; k < 3; k++) begin
            asserts++; if (slot0 !== 64'(8'h14 + 2*k) || slot1 !== 64'(8'h15 + 2*k)) begin errors++;
                $display("FAIL drain_%0d: got %h %h expected %h %h", k, slot0, slot1, 8'h14 + 2*k, 8'h15 + 2*k); end
            drive(0, 0, 2, 1'b0, 1'b0);
            step();
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        asserts++; if (iq_if.iq_size !== 4'd0 || iq_if.underflow_err !== 1'b0) begin errors++;
            $display("FAIL drain_end: got size=%0d udf=%b expected 0 0", iq_if.iq_size, iq_if.underflow_err); end
    endtask

    task automatic test_wrap();
        int mcount;
        int push_tag;
        int pop_tag;
        int np;
        int nq;
        mcount = 0; push_tag = 'h100; pop_tag = 'h100;
        for (int c = 0; c < 10; c++) begin
            np = (DEPTH - mcount >= 4) ? 4 : 0;
            nq = (mcount >= 2) ? 2 : 0;
            if (nq == 2) begin
                asserts++; if (slot0 !== 64'(pop_tag) || slot1 !== 64'(pop_tag + 1)) begin errors++;
                    $display("FAIL wrap_order_c%0d: got %h %h expected %h %h", c, slot0, slot1, pop_tag, pop_tag + 1); end
            end
            drive(np, push_tag, nq, 1'b0, 1'b0);
            step();
            mcount += np - nq; push_tag += np; pop_tag += nq;
            asserts++; if (32'(iq_if.iq_size) != mcount) begin errors++;
                $display("FAIL wrap_size_c%0d: got %0d expected %0d", c, iq_if.iq_size, mcount); end
        end
        for (int c = 0; c < 8 && mcount > 0; c++) begin
            asserts++; if (slot0 !== 64'(pop_tag) || slot1 !== 64'(pop_tag + 1)) begin errors++;
                $display("FAIL wrap_drain_c%0d: got %h %h expected %h %h", c, slot0, slot1, pop_tag, pop_tag + 1); end
            drive(0, 0, 2, 1'b0, 1'b0);
            step();
            mcount -= 2; pop_tag += 2;
        end
        drive(0, 0, 0, 1'b0, 1'b0);
        asserts++; if (iq_if.iq_size !== 4'd0 || iq_if.out_valid !== 2'b00) begin errors++;
            $display("FAIL wrap_empty: got size=%0d valid=%b expected 0 00", iq_if.iq_size, iq_if.out_valid); end
    endtask

    task automatic test_underflow();
        drive(1, 'h55, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.out_valid !== 2'b01) begin errors++; $display("FAIL udf_valid: got %b expected 01", iq_if.out_valid); end
        drive(0, 0, 2, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.underflow_err !== 1'b1 || iq_if.iq_size !== 4'd0) begin errors++;
            $display("FAIL udf_pulse: got udf=%b size=%0d expected 1 0", iq_if.underflow_err, iq_if.iq_size); end
        drive(0, 0, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.underflow_err !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", iq_if.underflow_err); end
        drive(1, 'h56, 0, 1'b0, 1'b0);
        step();
        drive(0, 0, 2, 1'b1, 1'b0);
        step();
        asserts++; if (iq_if.iq_size !== 4'd1 || iq_if.underflow_err !== 1'b0 || slot0 !== 64'h56) begin errors++;
            $display("FAIL stall_hold: got size=%0d udf=%b s0=%h expected 1 0 56", iq_if.iq_size, iq_if.underflow_err, slot0); end
        drive(0, 0, 1, 1'b0, 1'b0);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
        asserts++; if (iq_if.iq_size !== 4'd0 || iq_if.underflow_err !== 1'b0) begin errors++;
            $display("FAIL exact_pop: got size=%0d udf=%b expected 0 0", iq_if.iq_size, iq_if.underflow_err); end
    endtask

    task automatic test_flash();
        drive(4, 'h61, 0, 1'b0, 1'b0);
        step();
        drive(1, 'h65, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.iq_size !== 4'd5) begin errors++; $display("FAIL pre_flash_size: got %0d expected 5", iq_if.iq_size); end
        drive(3, 'h70, 2, 1'b0, 1'b1);
        step();
        asserts++; if (iq_if.iq_size !== 4'd0 || iq_if.iq_size_left !== 4'd8 || iq_if.out_valid !== 2'b00) begin errors++;
            $display("FAIL flash_state: got size=%0d left=%0d valid=%b expected 0 8 00", iq_if.iq_size, iq_if.iq_size_left, iq_if.out_valid); end
        asserts++; if (iq_if.overflow_err !== 1'b0 || iq_if.underflow_err !== 1'b0) begin errors++;
            $display("FAIL flash_err: got ovf=%b udf=%b expected 0 0", iq_if.overflow_err, iq_if.underflow_err); end
        drive(1, 'h77, 0, 1'b0, 1'b0);
        step();
        asserts++; if (slot0 !== 64'h77 || iq_if.out_valid !== 2'b01) begin errors++;
            $display("FAIL post_flash_push: got s0=%h valid=%b expected 77 01", slot0, iq_if.out_valid); end
        drive(0, 0, 1, 1'b0, 1'b0);
        step();
        drive(0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal_count();
        drive(5, 'h80, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.overflow_err !== 1'b1 || iq_if.iq_size !== 4'd0) begin errors++;
            $display("FAIL illegal_push: got ovf=%b size=%0d expected 1 0", iq_if.overflow_err, iq_if.iq_size); end
        drive(0, 0, 0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        drive(4, 'h90, 0, 1'b0, 1'b0);
        step();
        drive(4, 'h94, 0, 1'b0, 1'b0);
        step();
        drive(1, 'h98, 0, 1'b0, 1'b0);
        step();
        asserts++; if (iq_if.overflow_err !== 1'b1 || iq_if.iq_size !== 4'd8) begin errors++;
            $display("FAIL burst_full: got ovf=%b size=%0d expected 1 8", iq_if.overflow_err, iq_if.iq_size); end
        #2;
        rst_n = 1'b0;
        #1;
        asserts++; if (iq_if.iq_size !== 4'd0 || iq_if.iq_size_left !== 4'd8 || iq_if.out_valid !== 2'b00) begin errors++;
            $display("FAIL async_rst_state: got size=%0d left=%0d valid=%b expected 0 8 00", iq_if.iq_size, iq_if.iq_size_left, iq_if.out_valid); end
        asserts++; if (iq_if.overflow_err !== 1'b0 || iq_if.almost_full !== 1'b0) begin errors++;
            $display("FAIL async_rst_flags: got ovf=%b af=%b expected 0 0", iq_if.overflow_err, iq_if.almost_full); end
        drive(0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        asserts++; if (iq_if.iq_size !== 4'd0) begin errors++; $display("FAIL post_rst_size: got %0d expected 0", iq_if.iq_size); end
    endtask

    initial begin
        asserts = 0;
        errors  = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_wrap();
        test_underflow();
        test_flash();
        test_illegal_count();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end
endmodule

// File: doc/issue_queue_multiport.md
Name: issue_queue_multiport

Overview:
- Parametrised multi-issue instruction queue between decode and issue.
- Accepts up to PUSH_W decoded elements per cycle and presents up to POP_W oldest elements to issue.
- Successor to the fixed 4-in/2-out issue queue: configurable depth, port counts and element width, with stall-gated pop, overflow/underflow error flags and an almost-full indicator.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2*PUSH_W
PUSH_W, 4, max elements pushed per cycle
POP_W, 2, max elements popped per cycle
ELEM_W, 64, bits per queue element (packed issue-queue element)
AF_THRESH, 4, almost_full asserted when free entries < AF_THRESH

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
flash  in  1  synchronous flush; clears queue
stall  in  1  blocks pop this cycle; push unaffected
in_data  in  PUSH_W*ELEM_W  push elements; slot 0 = oldest
in_data_number  in  clog2(PUSH_W+1)  number of valid push slots (low slots)
out_data_number  in  clog2(POP_W+1)  number of elements issue consumes this cycle
out_data  out  POP_W*ELEM_W  oldest POP_W entries; slot 0 = head
out_valid  out  POP_W  bit i set when out_data slot i holds a live entry
iq_size  out  clog2(DEPTH+1)  occupied entries
iq_size_left  out  clog2(DEPTH+1)  free entries (DEPTH - iq_size)
almost_full  out  1  iq_size_left < AF_THRESH
overflow_err  out  1  registered one-cycle pulse: push rejected
underflow_err  out  1  registered one-cycle pulse: pop request clamped

Behaviour:
- Storage: DEPTH x ELEM_W register array; head/tail pointers of clog2(DEPTH) bits wrap modulo DEPTH; separate count register.
- Reset (rst_n low, async): head=0, tail=0, count=0, overflow_err=0, underflow_err=0. Hence iq_size=0, iq_size_left=DEPTH, out_valid=0, almost_full=(DEPTH<AF_THRESH). Array contents are not reset; out_data is don't-care while out_valid=0.
- Outputs iq_size, iq_size_left, almost_full, out_valid and out_data are combinational from registered state only. They never depend on same-cycle push inputs, so a pushed element is visible at the earliest one cycle after the push.
- out_data slot i = array[(head+i) mod DEPTH]; out_valid[i] = (i < count).
- Pop: effective pop p = 0 if stall or flash; otherwise p = min(out_data_number, count).
  - If out_data_number > count and neither stall nor flash is asserted, underflow_err pulses next cycle.
  - head advances by p.
- Push: n = in_data_number.
  - Push is all-or-nothing against free entries at cycle start: accepted iff n <= iq_size_left (pre-pop value; same-cycle pops do not create space).
  - Accepted: slots 0..n-1 are written to tail..tail+n-1 mod DEPTH, and tail advances by n.
  - Rejected (n > iq_size_left, n != 0, no flash): nothing is written and overflow_err pulses next cycle.
  - in_data_number > PUSH_W is illegal; treated as a rejection.
- count_next = count + accepted_n - p. Push and pop in the same cycle are both legal.
- flash (sync, highest priority): next cycle head=tail=0 and count=0. Push and pop in the flash cycle are discarded; no error pulses.
- Error flags are one-cycle pulses and are cleared the following cycle unless the condition recurs.
- Wrap-around: pushes spanning index DEPTH-1 -> 0 are split correctly. Full (count=DEPTH) and empty (count=0) are distinguished by count, never by pointer equality.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- Reset then idle (DEPTH=8, PUSH_W=4, POP_W=2) -> iq_size=0, iq_size_left=8, out_valid=00, almost_full=0, both error flags 0.
- Push 4 elements 0x11..0x14, then out_data_number=1 with push 3 elements 0x15..0x17:
  - Cycle after the first push: out_data={0x12,0x11}, out_valid=11.
  - After the second cycle: iq_size=6, head slot=0x12, almost_full=1 (left=2<4).
- Fill to 8, then push 1 with pop 2 in the same cycle -> push rejected (left=0), overflow_err pulses 1 cycle, iq_size=6.
- Wrap: cycle pushes of 4 and pops of 2 over 10 cycles with sequential tags -> pop order strictly sequential across index 7->0, no loss or duplication.
- iq_size=1, out_data_number=2 -> one element popped, underflow_err pulses; same request with stall=1 -> no pop, no underflow_err.
- iq_size=5, flash=1 with push 3 and pop 2 -> next cycle iq_size=0, iq_size_left=8, out_valid=00, no error pulses; rst_n dropped mid-burst -> all outputs at reset values without a clock edge.
